// File: rtl/fpu_defs.sv
// Shared FPU definitions: opcode encodings, exception flag layout and operand class record.
package fpu_defs;

    localparam logic [3:0] C_FPU_ADD_CMD = 4'd0;
    localparam logic [3:0] C_FPU_SUB_CMD = 4'd1;
    localparam logic [3:0] C_FPU_MUL_CMD = 4'd2;
    localparam logic [3:0] C_FPU_DIV_CMD = 4'd3;
    localparam logic [3:0] C_FPU_I2F_CMD = 4'd4;
    localparam logic [3:0] C_FPU_F2I_CMD = 4'd5;

    // Bit position of each flag inside the 6-bit {OF,UF,Zero,IX,IV,Inf} vector.
    typedef enum logic [2:0] {
        FLAG_INF  = 3'd0,
        FLAG_IV   = 3'd1,
        FLAG_IX   = 3'd2,
        FLAG_ZERO = 3'd3,
        FLAG_UF   = 3'd4,
        FLAG_OF   = 3'd5
    } flag_idx_e;

    typedef struct packed {
        logic of;
        logic uf;
        logic zero;
        logic ix;
        logic iv;
        logic inf;
    } fflags_t;

    typedef struct packed {
        logic inf;
        logic nan;
        logic zero;
    } opcls_t;

    // Sticky/trap view of a flag vector, ordered {IV,OF,UF,IX}.
    function automatic logic [3:0] sticky_bits(fflags_t f);
        return {f.iv, f.of, f.uf, f.ix};
    endfunction

endpackage

// File: rtl/fpexc_pipe_if.sv
// Entry handshake bundle: operand/rounder inputs on the input side, resolved flags on the output side.
interface fpexc_pipe_if #(
    parameter int C_EXP_W  = 8,
    parameter int C_MANT_W = 23,
    parameter int C_CMD_W  = 4
);
    logic                In_Valid_SI;
    logic                In_Ready_SO;
    logic [C_MANT_W:0]   Mant_a_DI;
    logic [C_MANT_W:0]   Mant_b_DI;
    logic [C_EXP_W-1:0]  Exp_a_DI;
    logic [C_EXP_W-1:0]  Exp_b_DI;
    logic                Sign_a_DI;
    logic                Sign_b_DI;
    logic [C_MANT_W:0]   Mant_norm_DI;
    logic [C_CMD_W-1:0]  Op_SI;
    logic                Mant_rounded_SI;
    logic                Exp_OF_SI;
    logic                Exp_UF_SI;
    logic [5:0]          Cvt_flags_DI;
    logic                Out_Valid_SO;
    logic                Out_Ready_SI;
    logic                Exp_toZero_SO;
    logic                Exp_toInf_SO;
    logic                Mant_toZero_SO;
    logic [5:0]          Flags_DO;

    modport master (
        output In_Valid_SI, Mant_a_DI, Mant_b_DI, Exp_a_DI, Exp_b_DI, Sign_a_DI, Sign_b_DI,
               Mant_norm_DI, Op_SI, Mant_rounded_SI, Exp_OF_SI, Exp_UF_SI, Cvt_flags_DI,
               Out_Ready_SI,
        input  In_Ready_SO, Out_Valid_SO, Exp_toZero_SO, Exp_toInf_SO, Mant_toZero_SO, Flags_DO
    );

    modport slave (
        input  In_Valid_SI, Mant_a_DI, Mant_b_DI, Exp_a_DI, Exp_b_DI, Sign_a_DI, Sign_b_DI,
               Mant_norm_DI, Op_SI, Mant_rounded_SI, Exp_OF_SI, Exp_UF_SI, Cvt_flags_DI,
               Out_Ready_SI,
        output In_Ready_SO, Out_Valid_SO, Exp_toZero_SO, Exp_toInf_SO, Mant_toZero_SO, Flags_DO
    );
endinterface

// File: rtl/fpexc_classify.sv
// Combinational operand classifier: Inf / NaN / Zero from exponent and full mantissa.
module fpexc_classify
    import fpu_defs::*;
#(
    parameter int C_EXP_W  = 8,
    parameter int C_MANT_W = 23
) (
    input  logic [C_EXP_W-1:0] Exp_DI,
    input  logic [C_MANT_W:0]  Mant_DI,
    output opcls_t             Class_DO
);
    logic exp_ones;
    logic frac_nz;

    // The hidden bit is ignored for Inf/NaN but counts towards a true zero.
    assign exp_ones      = &Exp_DI;
    assign frac_nz       = |Mant_DI[C_MANT_W-1:0];
    assign Class_DO.inf  = exp_ones & ~frac_nz;
    assign Class_DO.nan  = exp_ones & frac_nz;
    assign Class_DO.zero = ~(|Exp_DI) & ~(|Mant_DI);
endmodule

// File: rtl/fpexc_pipe.sv
// Two-stage FPU exception stage: S1 classifies operands, S2 resolves flags/controls; sticky flags and trap.
module fpexc_pipe
    import fpu_defs::*;
#(
    parameter int C_EXP_W  = 8,
    parameter int C_MANT_W = 23,
    parameter int C_CMD_W  = 4
) (
    input  logic         Clk_CI,
    input  logic         Rst_RI,
    input  logic         Flush_SI,
    fpexc_pipe_if.slave  io,
    output logic [3:0]   Sticky_DO,
    input  logic         Sticky_wr_SI,
    input  logic [3:0]   Sticky_wdata_DI,
    input  logic [3:0]   Trap_en_DI,
    output logic         Trap_SO
);
    logic [C_EXP_W-1:0] exp_op  [2];
    logic [C_MANT_W:0]  mant_op [2];
    opcls_t             cls_op  [2];

    assign exp_op[0]  = io.Exp_a_DI;
    assign exp_op[1]  = io.Exp_b_DI;
    assign mant_op[0] = io.Mant_a_DI;
    assign mant_op[1] = io.Mant_b_DI;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cls
        fpexc_classify #(.C_EXP_W(C_EXP_W), .C_MANT_W(C_MANT_W)) u_cls (
            .Exp_DI   (exp_op[gi]),
            .Mant_DI  (mant_op[gi]),
            .Class_DO (cls_op[gi])
        );
    end

    // S1 state
    logic               v1_q;
    opcls_t             cls_a_q, cls_b_q;
    logic               mant_z_q, sign_a_q, sign_b_q, rnd_q, eof_q, euf_q;
    logic [C_CMD_W-1:0] op_q;
    fflags_t            cvt_q;
    // S2 state
    logic               v2_q;
    fflags_t            flags_q;
    logic               to_zero_q, to_inf_q, mant_to_zero_q;
    logic [3:0]         sticky_q;
    logic               trap_q;

    logic rdy2, en1, ret;
    assign rdy2 = ~v2_q | io.Out_Ready_SI;
    assign en1  = ~v1_q | rdy2;
    assign ret  = v2_q & io.Out_Ready_SI;

    logic is_addsub, is_mul, is_i2f, is_f2i;
    assign is_addsub = (op_q == C_CMD_W'(C_FPU_ADD_CMD)) || (op_q == C_CMD_W'(C_FPU_SUB_CMD));
    assign is_mul    = (op_q == C_CMD_W'(C_FPU_MUL_CMD));
    assign is_i2f    = (op_q == C_CMD_W'(C_FPU_I2F_CMD));
    assign is_f2i    = (op_q == C_CMD_W'(C_FPU_F2I_CMD));

    fflags_t flags_d;
    logic    iv_c, inf_t_c, ovf_c, of_c;
    logic    to_zero_d, to_inf_d;

    always_comb begin
        iv_c    = 1'b0;
        inf_t_c = 1'b0;
        if (is_addsub) begin
            iv_c    = (cls_a_q.inf & cls_b_q.inf & (sign_a_q ^ sign_b_q)) | cls_a_q.nan | cls_b_q.nan;
            inf_t_c = (cls_a_q.inf ^ cls_b_q.inf) | (cls_a_q.inf & cls_b_q.inf & ~(sign_a_q ^ sign_b_q));
        end else if (is_mul) begin
            iv_c    = (cls_a_q.inf & cls_b_q.zero) | (cls_b_q.inf & cls_a_q.zero) | cls_a_q.nan | cls_b_q.nan;
            inf_t_c = (cls_a_q.inf & ~cls_b_q.zero) | (cls_b_q.inf & ~cls_a_q.zero);
        end
        ovf_c        = eof_q & ~mant_z_q;
        of_c         = ovf_c | (~iv_c & (cls_a_q.inf ^ cls_b_q.inf) & ~is_i2f);
        flags_d.of   = of_c;
        flags_d.uf   = euf_q & rnd_q;
        flags_d.zero = mant_z_q & ~iv_c;
        flags_d.ix   = rnd_q | of_c;
        flags_d.iv   = iv_c;
        flags_d.inf  = inf_t_c | ovf_c;
        // Conversions report the converter's own status verbatim.
        if (is_f2i) begin
            flags_d = cvt_q;
        end
        to_inf_d  = flags_d.of | flags_d.iv;
        to_zero_d = is_i2f ? (cls_a_q.zero & ~sign_a_q) : (euf_q | (mant_z_q & ~to_inf_d));
    end

    logic [3:0] sticky_d;
    logic       trap_d;
    assign sticky_d = (Sticky_wr_SI ? Sticky_wdata_DI : sticky_q) | (ret ? sticky_bits(flags_q) : 4'b0);
    assign trap_d   = ret & |(sticky_bits(flags_q) & Trap_en_DI);

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            v1_q           <= 1'b0;
            cls_a_q        <= '0;
            cls_b_q        <= '0;
            mant_z_q       <= 1'b0;
            sign_a_q       <= 1'b0;
            sign_b_q       <= 1'b0;
            rnd_q          <= 1'b0;
            eof_q          <= 1'b0;
            euf_q          <= 1'b0;
            op_q           <= '0;
            cvt_q          <= '0;
            v2_q           <= 1'b0;
            flags_q        <= '0;
            to_zero_q      <= 1'b0;
            to_inf_q       <= 1'b0;
            mant_to_zero_q <= 1'b0;
            sticky_q       <= 4'b0;
            trap_q         <= 1'b0;
        end else begin
            if (Flush_SI)  v1_q <= 1'b0;
            else if (en1)  v1_q <= io.In_Valid_SI;
            if (en1 && io.In_Valid_SI) begin
                cls_a_q  <= cls_op[0];
                cls_b_q  <= cls_op[1];
                mant_z_q <= ~(|io.Mant_norm_DI);
                sign_a_q <= io.Sign_a_DI;
                sign_b_q <= io.Sign_b_DI;
                rnd_q    <= io.Mant_rounded_SI;
                eof_q    <= io.Exp_OF_SI;
                euf_q    <= io.Exp_UF_SI;
                op_q     <= io.Op_SI;
                cvt_q    <= fflags_t'(io.Cvt_flags_DI);
            end
            if (Flush_SI)  v2_q <= 1'b0;
            else if (rdy2) v2_q <= v1_q;
            // Outputs only move when a real entry advances, so idle output values stay stable.
            if (rdy2 && v1_q) begin
                flags_q        <= flags_d;
                to_zero_q      <= to_zero_d;
                to_inf_q       <= to_inf_d;
                mant_to_zero_q <= flags_d.inf;
            end
            sticky_q <= sticky_d;
            trap_q   <= trap_d;
        end
    end

    assign io.In_Ready_SO    = en1;
    assign io.Out_Valid_SO   = v2_q;
    assign io.Flags_DO       = flags_q;
    assign io.Exp_toZero_SO  = to_zero_q;
    assign io.Exp_toInf_SO   = to_inf_q;
    assign io.Mant_toZero_SO = mant_to_zero_q;
    assign Sticky_DO         = sticky_q;
    assign Trap_SO           = trap_q;
endmodule

// File: tb/tb_fpexc_pipe.sv
// Directed self-checking bench for fpexc_pipe: flag resolution, handshake, sticky/trap, flush and reset.
module tb_fpexc_pipe;
    import fpu_defs::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [3:0] sticky;
    logic       sticky_wr;
    logic [3:0] sticky_wdata;
    logic [3:0] trap_en;
    logic       trap;

    int n_chk  = 0;
    int n_fail = 0;

    fpexc_pipe_if #(.C_EXP_W(8), .C_MANT_W(23), .C_CMD_W(4)) io ();

    fpexc_pipe #(.C_EXP_W(8), .C_MANT_W(23), .C_CMD_W(4)) dut (
        .Clk_CI          (clk),
        .Rst_RI          (rst),
        .Flush_SI        (flush),
        .io              (io),
        .Sticky_DO       (sticky),
        .Sticky_wr_SI    (sticky_wr),
        .Sticky_wdata_DI (sticky_wdata),
        .Trap_en_DI      (trap_en),
        .Trap_SO         (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] op,
                          input logic [7:0] ea, input logic [23:0] ma, input logic sa,
                          input logic [7:0] eb, input logic [23:0] mb, input logic sb,
                          input logic [23:0] mn, input logic rnd, input logic eof,
                          input logic euf, input logic [5:0] cvt);
        io.Op_SI           = op;
        io.Exp_a_DI        = ea;
        io.Mant_a_DI       = ma;
        io.Sign_a_DI       = sa;
        io.Exp_b_DI        = eb;
        io.Mant_b_DI       = mb;
        io.Sign_b_DI       = sb;
        io.Mant_norm_DI    = mn;
        io.Mant_rounded_SI = rnd;
        io.Exp_OF_SI       = eof;
        io.Exp_UF_SI       = euf;
        io.Cvt_flags_DI    = cvt;
        io.In_Valid_SI     = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; sticky_wr = 1'b0; sticky_wdata = 4'h0; trap_en = 4'h0;
        io.Out_Ready_SI = 1'b1;
        set_in(C_FPU_ADD_CMD, 8'h0, 24'h0, 1'b0, 8'h0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 6'h0);
        io.In_Valid_SI = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(io.Out_Valid_SO), 32'd0);
        chk("rst_sticky", 32'(sticky), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_flags", 32'(io.Flags_DO), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(io.In_Ready_SO), 32'd1);

        // ADD +Inf + -Inf: invalid
        set_in(C_FPU_ADD_CMD, 8'hFF, 24'h800000, 1'b0, 8'hFF, 24'h800000, 1'b1, 24'h800000, 1'b0, 1'b0, 1'b0, 6'h0);
        @(negedge clk); io.In_Valid_SI = 1'b0;
        @(negedge clk);
        chk("add_inf_valid", 32'(io.Out_Valid_SO), 32'd1);
        chk("add_inf_flags", 32'(io.Flags_DO), 32'b000010);
        chk("add_inf_toinf", 32'(io.Exp_toInf_SO), 32'd1);
        chk("add_inf_tozero", 32'(io.Exp_toZero_SO), 32'd0);
        chk("add_inf_mtz", 32'(io.Mant_toZero_SO), 32'd0);
        @(negedge clk);
        chk("add_inf_sticky", 32'(sticky), 32'b1000);
        chk("add_inf_drained", 32'(io.Out_Valid_SO), 32'd0);

        sticky_wr = 1'b1; sticky_wdata = 4'h0;
        @(negedge clk); sticky_wr = 1'b0;
        chk("csr_clear", 32'(sticky), 32'd0);

        // MUL +Inf * +0: invalid, no overflow
        set_in(C_FPU_MUL_CMD, 8'hFF, 24'h800000, 1'b0, 8'h00, 24'h000000, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 6'h0);
        @(negedge clk); io.In_Valid_SI = 1'b0;
        @(negedge clk);
        chk("mul_inf0_flags", 32'(io.Flags_DO), 32'b000010);
        chk("mul_inf0_toinf", 32'(io.Exp_toInf_SO), 32'd1);
        @(negedge clk);
        chk("mul_inf0_sticky", 32'(sticky), 32'b1000);

        // MUL +Inf * 1.0: infinite result
        set_in(C_FPU_MUL_CMD, 8'hFF, 24'h800000, 1'b0, 8'h7F, 24'h800000, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 6'h0);
        @(negedge clk); io.In_Valid_SI = 1'b0;
        @(negedge clk);
        chk("mul_inf1_flags", 32'(io.Flags_DO), 32'b100101);
        chk("mul_inf1_mtz", 32'(io.Mant_toZero_SO), 32'd1);
        chk("mul_inf1_toinf", 32'(io.Exp_toInf_SO), 32'd1);
        chk("mul_inf1_tozero", 32'(io.Exp_toZero_SO), 32'd0);
        @(negedge clk);
        chk("mul_inf1_sticky", 32'(sticky), 32'b1101);

        // I2F of +0
        set_in(C_FPU_I2F_CMD, 8'h00, 24'h000000, 1'b0, 8'h00, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 6'h0);
        @(negedge clk); io.In_Valid_SI = 1'b0;
        @(negedge clk);
        chk("i2f_zero_flags", 32'(io.Flags_DO), 32'b001000);
        chk("i2f_zero_tozero", 32'(io.Exp_toZero_SO), 32'd1);
        chk("i2f_zero_toinf", 32'(io.Exp_toInf_SO), 32'd0);
        @(negedge clk);
        chk("i2f_zero_sticky", 32'(sticky), 32'b1101);

        sticky_wr = 1'b1; sticky_wdata = 4'h0;
        @(negedge clk); sticky_wr = 1'b0;

        // F2I passes converter status through
        set_in(C_FPU_F2I_CMD, 8'h7F, 24'h800000, 1'b0, 8'h7F, 24'h800000, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 6'b000110);
        @(negedge clk); io.In_Valid_SI = 1'b0;
        @(negedge clk);
        chk("f2i_flags", 32'(io.Flags_DO), 32'b000110);
        chk("f2i_toinf", 32'(io.Exp_toInf_SO), 32'd1);
        chk("f2i_tozero", 32'(io.Exp_toZero_SO), 32'd0);
        @(negedge clk);
        chk("f2i_sticky", 32'(sticky), 32'b1001);
        chk("f2i_trap_masked", 32'(trap), 32'd0);

        // CSR clear merged with a retiring inexact entry, trap enabled on IX
        trap_en = 4'b0001;
        set_in(C_FPU_ADD_CMD, 8'h80, 24'hC00000, 1'b0, 8'h80, 24'hA00000, 1'b0, 24'h900000, 1'b1, 1'b0, 1'b0, 6'h0);
        @(negedge clk); io.In_Valid_SI = 1'b0;
        @(negedge clk);
        chk("ix_flags", 32'(io.Flags_DO), 32'b000100);
        sticky_wr = 1'b1; sticky_wdata = 4'h0;
        @(negedge clk); sticky_wr = 1'b0;
        chk("merge_sticky", 32'(sticky), 32'b0001);
        chk("merge_trap", 32'(trap), 32'd1);
        @(negedge clk);
        chk("trap_one_cycle", 32'(trap), 32'd0);

        // Back-pressure over three back-to-back entries
        io.Out_Ready_SI = 1'b0;
        set_in(C_FPU_F2I_CMD, 8'h7F, 24'h800000, 1'b0, 8'h7F, 24'h800000, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 6'b000001);
        @(negedge clk);
        chk("bp_ready_after_1st", 32'(io.In_Ready_SO), 32'd1);
        io.Cvt_flags_DI = 6'b001000;
        @(negedge clk);
        chk("bp_ready_after_2nd", 32'(io.In_Ready_SO), 32'd0);
        io.Cvt_flags_DI = 6'b010000;
        @(negedge clk);
        chk("bp_ready_stalled", 32'(io.In_Ready_SO), 32'd0);
        chk("bp_hold_valid", 32'(io.Out_Valid_SO), 32'd1);
        chk("bp_hold_a", 32'(io.Flags_DO), 32'b000001);
        io.Out_Ready_SI = 1'b1;
        @(negedge clk); io.In_Valid_SI = 1'b0;
        chk("bp_order_b", 32'(io.Flags_DO), 32'b001000);
        chk("bp_valid_b", 32'(io.Out_Valid_SO), 32'd1);
        @(negedge clk);
        chk("bp_order_c", 32'(io.Flags_DO), 32'b010000);
        chk("bp_valid_c", 32'(io.Out_Valid_SO), 32'd1);
        @(negedge clk);
        chk("bp_drained", 32'(io.Out_Valid_SO), 32'd0);
        chk("bp_sticky", 32'(sticky), 32'b0011);
        chk("bp_no_trap", 32'(trap), 32'd0);

        // Flush with both stages full
        io.Out_Ready_SI = 1'b0;
        set_in(C_FPU_F2I_CMD, 8'h7F, 24'h800000, 1'b0, 8'h7F, 24'h800000, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 6'b000100);
        @(negedge clk);
        @(negedge clk);
        chk("fl_full_valid", 32'(io.Out_Valid_SO), 32'd1);
        chk("fl_full_ready", 32'(io.In_Ready_SO), 32'd0);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0; io.In_Valid_SI = 1'b0;
        chk("fl_out_valid", 32'(io.Out_Valid_SO), 32'd0);
        chk("fl_sticky", 32'(sticky), 32'b0011);
        chk("fl_in_ready", 32'(io.In_Ready_SO), 32'd1);
        @(negedge clk);
        chk("fl_s1_cleared", 32'(io.Out_Valid_SO), 32'd0);

        // Input handshake in the flush cycle is discarded
        io.Out_Ready_SI = 1'b1;
        set_in(C_FPU_F2I_CMD, 8'h7F, 24'h800000, 1'b0, 8'h7F, 24'h800000, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 6'b000100);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0; io.In_Valid_SI = 1'b0;
        @(negedge clk);
        chk("fl_discard_valid", 32'(io.Out_Valid_SO), 32'd0);
        @(negedge clk);
        chk("fl_discard_sticky", 32'(sticky), 32'b0011);

        // Reset during a stall
        trap_en = 4'b1111;
        io.Out_Ready_SI = 1'b0;
        set_in(C_FPU_F2I_CMD, 8'h7F, 24'h800000, 1'b0, 8'h7F, 24'h800000, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 6'b100000);
        @(negedge clk);
        @(negedge clk); io.In_Valid_SI = 1'b0;
        chk("rs_stall_valid", 32'(io.Out_Valid_SO), 32'd1);
        chk("rs_stall_flags", 32'(io.Flags_DO), 32'b100000);
        rst = 1'b1; io.Out_Ready_SI = 1'b1;
        @(negedge clk);
        chk("rs_out_valid", 32'(io.Out_Valid_SO), 32'd0);
        chk("rs_flags", 32'(io.Flags_DO), 32'd0);
        chk("rs_sticky", 32'(sticky), 32'd0);
        chk("rs_trap", 32'(trap), 32'd0);
        chk("rs_toinf", 32'(io.Exp_toInf_SO), 32'd0);
        chk("rs_in_ready", 32'(io.In_Ready_SO), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_post_trap", 32'(trap), 32'd0);
        chk("rs_post_valid", 32'(io.Out_Valid_SO), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fpexc_pipe.md
Name: fpexc_pipe

Overview:
Parametrised, pipelined successor to the FPU exception stage. Classifies operands, resolves the per-operation IEEE flags and the result-manipulation controls, and registers them behind a valid/ready handshake. Accumulates sticky exception flags (fflags-style) with a CSR write/clear port and a maskable trap pulse. Sits between the normaliser/rounder and the result-assembly stage of the FPU.

Parameters:
C_EXP_W, 8, exponent width
C_MANT_W, 23, fraction width; mantissa inputs are C_MANT_W+1 bits including the hidden bit
C_CMD_W, 4, opcode width; encodings come from fpu_defs

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  synchronous active-high reset
Flush_SI  in  1  drop all in-flight entries
In_Valid_SI  in  1  input entry valid
In_Ready_SO  out  1  input accepted when both valid and ready are high
Mant_a_DI, Mant_b_DI  in  C_MANT_W+1  operand mantissas
Exp_a_DI, Exp_b_DI  in  C_EXP_W  operand exponents
Sign_a_DI, Sign_b_DI  in  1  operand signs
Mant_norm_DI  in  C_MANT_W+1  normalised result mantissa
Op_SI  in  C_CMD_W  opcode (ADD, SUB, MUL, F2I, I2F, others)
Mant_rounded_SI, Exp_OF_SI, Exp_UF_SI  in  1  rounder status
Cvt_flags_DI  in  6  F2I status {OF,UF,Zero,IX,IV,Inf}
Out_Valid_SO  out  1  result entry valid
Out_Ready_SI  in  1  downstream ready
Exp_toZero_SO, Exp_toInf_SO, Mant_toZero_SO  out  1  result-manipulation controls
Flags_DO  out  6  per-op {OF,UF,Zero,IX,IV,Inf}
Sticky_DO  out  4  accumulated {IV,OF,UF,IX}
Sticky_wr_SI  in  1  CSR write strobe
Sticky_wdata_DI  in  4  CSR write data
Trap_en_DI  in  4  trap enable mask, same bit order as Sticky_DO
Trap_SO  out  1  one-cycle trap pulse

Behaviour:
- Reset: all valid bits 0, Sticky_DO=0, Trap_SO=0, all registered outputs 0. In_Ready_SO=1 in the cycle after reset.
- Two stages. S1 registers the operand classes and the inputs needed by S2: InfX (exp all ones and fraction zero), NaNX (exp all ones and fraction nonzero), ZeroX (exp zero and full mantissa zero), MantZ (Mant_norm zero). S2 registers the resolved outputs.
- Latency is 2 cycles from the input handshake to Out_Valid_SO with no back-pressure.
- Ready logic: rdy2 = ~v2 | Out_Ready_SI; In_Ready_SO = ~v1 | rdy2. This sustains full throughput. A stalled stage holds its data.
- IV: ADD/SUB = (InfA&InfB&(Sa^Sb))|NaNA|NaNB. MUL = (InfA&ZeroB)|(InfB&ZeroA)|NaNA|NaNB. F2I = Cvt IV. All other ops = 0.
- For ops other than F2I:
  - OF = (Exp_OF&~MantZ) | (~IV&(InfA^InfB)&op≠I2F)
  - UF = Exp_UF&Mant_rounded
  - Zero = MantZ&~IV
  - IX = Mant_rounded|OF
  - Inf = InfT | (Exp_OF&~MantZ)
  - InfT for ADD/SUB = (InfA^InfB)|(InfA&InfB&~(Sa^Sb)); InfT for MUL = (InfA&~ZeroB)|(InfB&~ZeroA); InfT = 0 otherwise.
- For F2I: each flag is the corresponding Cvt_flags_DI bit.
- Exp_toInf = OF|IV. Exp_toZero = I2F ? (ZeroA&~SignA) : Exp_UF|(MantZ&~Exp_toInf). Mant_toZero = Inf.
- Sticky update: next = (Sticky_wr ? wdata : Sticky) | (ret ? {IV,OF,UF,IX} : 0), where ret = Out_Valid&Out_Ready. A CSR write and a retire in the same cycle merge, so the retiring flags are never lost.
- Trap_SO = registered (ret & |({IV,OF,UF,IX} & Trap_en_DI)). It rises one cycle after the retire.
- Flush: v1 and v2 are cleared next cycle; Sticky is unaffected; an input handshake in the flush cycle is discarded. A retire in the flush cycle still updates Sticky. Flush and reset together: reset wins.
- Reset mid-stall: all state is cleared and no trap is issued.

Decomposition:
- In fpu_defs: C_FPU_*_CMD opcodes, a flag-index enum (OF, UF, ZERO, IX, IV, INF), and a packed struct for the 6-bit flag vector.
- One natural sub-module, fpexc_classify: combinational per-operand Inf/NaN/Zero detection, instantiated twice in S1.

Test Plan:
- ADD with a=+Inf (exp 0xFF, frac 0) and b=-Inf -> after 2 cycles IV=1, Exp_toInf=1, Inf=0, Zero=0; Sticky becomes 4'b1000.
- MUL with a=+Inf and b=+0 -> IV=1, OF=0. MUL with a=+Inf and b=1.0 -> Inf=1, OF=1, IX=1, Mant_toZero=1.
- I2F with a=+0 -> Exp_toZero=1, OF=0. F2I with Cvt_flags=6'b000110 -> Flags_DO=6'b000110, Sticky IX and IV set.
- Back-pressure: hold Out_Ready=0 over 3 back-to-back inputs -> In_Ready drops after the 2nd; no loss or reorder after release.
- Sticky_wr with wdata=0 in the same cycle as retiring an entry with IX=1 -> Sticky=4'b0001. With Trap_en=4'b0001 -> Trap_SO pulses 1 cycle later.
- Flush with both stages full -> Out_Valid=0 next cycle, Sticky unchanged. Reset during a stall -> all outputs 0.
